fifo_param_v2: RTL

- Parametrised synchronous FIFO. Next generation of the team's 8-bit/16-deep FIFO.
- Adds configurable width and depth, and optional first-word-fall-through (FWFT) read mode.
- Adds almost-full/almost-empty thresholds, an occupancy level output and a synchronous flush.
- Adds saturating overflow/underflow event counters, so benches and SoC status logic no longer count error edges externally.

---
 rtl/fifo_param_v2.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fifo_param_v2.sv
// Parametrised synchronous FIFO with optional first-word-fall-through read.
// Latency: FWFT=0 dout valid one cycle after an accepted read; FWFT=1 head visible the cycle after the write.
// Backpressure: writes are rejected when full (unless a read frees a slot in the same cycle),
// reads are rejected when empty; each rejection gives a one-cycle pulse and a saturating count.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush, err_clr      synchronous clear of contents / of both event counters
//   wt_en, din          write request and data
//   rd_en, dout         read request and data
//   full, empty, almost_full, almost_empty, level   occupancy status
//   overflow, underflow, ovf_cnt, unf_cnt           rejected-request pulses and counters
module fifo_param_v2 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  parameter int FWFT   = 0,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       err_clr,
  input  logic                       wt_en,
  input  logic [DATA_W-1:0]          din,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow,
  output logic [CNT_W-1:0]           ovf_cnt,
  output logic [CNT_W-1:0]           unf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    LVL_FULL = PW'(DEPTH);
  localparam logic [PW-1:0]    LVL_AF   = PW'(AF_LVL);
  localparam logic [PW-1:0]    LVL_AE   = PW'(AE_LVL);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wt_p_q, wt_p_d;
  logic [PW-1:0]    rd_p_q, rd_p_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] unf_cnt_q, unf_cnt_d;
  logic             rd_ok, wr_ok;
  logic [AW-1:0]    wt_idx, rd_idx;

  // Pointers carry an extra wrap bit, so the modulo difference is the
  // occupancy and distinguishes full from empty without extra state.
  assign level        = wt_p_q - rd_p_q;
  assign full         = (level == LVL_FULL);
  assign empty        = (level == '0);
  assign almost_full  = (level >= LVL_AF);
  assign almost_empty = (level <= LVL_AE);

  assign wt_idx = wt_p_q[AW-1:0];
  assign rd_idx = rd_p_q[AW-1:0];

  // Flush masks all traffic. A full FIFO still takes a write when a read
  // pops in the same cycle; an empty FIFO never bypasses write data to a read.
  assign rd_ok = rd_en && !empty && !flush;
  assign wr_ok = wt_en && !flush && (!full || rd_ok);

  always_comb begin
    wt_p_d    = wt_p_q;
    rd_p_d    = rd_p_q;
    ovf_d     = 1'b0;
    unf_d     = 1'b0;
    ovf_cnt_d = ovf_cnt_q;
    unf_cnt_d = unf_cnt_q;

    if (flush) begin
      wt_p_d = '0;
      rd_p_d = '0;
    end else begin
      if (wr_ok) wt_p_d = wt_p_q + 1'b1;
      if (rd_ok) rd_p_d = rd_p_q + 1'b1;
      ovf_d = wt_en && !wr_ok;
      unf_d = rd_en && !rd_ok;
    end

    // Counters follow the registered pulses; err_clr wins over an increment.
    if (err_clr) begin
      ovf_cnt_d = '0;
      unf_cnt_d = '0;
    end else begin
      if (ovf_q && (ovf_cnt_q != CNT_MAX)) ovf_cnt_d = ovf_cnt_q + 1'b1;
      if (unf_q && (unf_cnt_q != CNT_MAX)) unf_cnt_d = unf_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_p_q    <= '0;
      rd_p_q    <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      wt_p_q    <= wt_p_d;
      rd_p_q    <= rd_p_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      ovf_cnt_q <= ovf_cnt_d;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wt_idx] <= din;
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign unf_cnt   = unf_cnt_q;

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is presented directly; forced to zero when nothing is stored.
      assign dout = empty ? '0 : mem_q[rd_idx];
    end else begin : g_reg
      logic [DATA_W-1:0] dout_q;
      // Register updates only on an accepted read; rejected reads and flush hold it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     dout_q <= '0;
        else if (rd_ok) dout_q <= mem_q[rd_idx];
      end
      assign dout = dout_q;
    end
  endgenerate

endmodule
